spi3w_slave_responder: RTL and testbench

Slave-side endpoint of the team's 3-wire half-duplex SPI link (SCLK plus a shared bidirectional SDIO). It decodes command frames from the master and executes the frame against a local register port.
- Write command: updates a register.
- Read command: turns the SDIO line around and shifts one response byte back to the master.
This is the responder for the master transmit path, so the link becomes register-addressable in both directions.

---
 rtl/spi3w_pkg.sv | 23 ++
 rtl/spi_edge_sync.sv | 33 +++
 rtl/spi3w_slave_responder.sv | 202 ++++++++++++++++++++
 tb/tb_spi3w_slave_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi3w_pkg.sv
// Shared definitions for the 3-wire SPI link (master and slave sides).
package spi3w_pkg;

    localparam int unsigned CMD_RW_BIT             = 7;
    localparam int unsigned ADDR_W                 = 7;
    localparam int unsigned DATA_W                 = 8;
    localparam int unsigned BIT_CNT_W              = 3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32;

    typedef enum logic [1:0] {
        S_CMD    = 2'd0,
        S_WDATA  = 2'd1,
        S_RTURN  = 2'd2,
        S_RDRIVE = 2'd3
    } spi3w_state_e;

    // A frame is in progress once any bit has been shifted or a data phase has begun.
    function automatic logic frame_active(input spi3w_state_e st,
                                          input logic [BIT_CNT_W-1:0] cnt);
        return (st != S_CMD) || (cnt != '0);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// SCLK synchronizer with rise/fall detect, plus an SDIO synchronizer whose output is
// time-aligned with the detected SCLK edges.
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sclk_in,
    input  logic sdio_in,
    output logic rise,
    output logic fall,
    output logic sdio_s
);

    logic [2:0] sclk_sync_q;
    logic [1:0] sdio_sync_q;

    // Shift both asynchronous inputs through their synchronizer chains.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sclk_sync_q <= '0;
            sdio_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk_in};
            sdio_sync_q <= {sdio_sync_q[0], sdio_in};
        end
    end

    // sdio_sync_q[1] carries the SDIO sample taken with the SCLK sample in sclk_sync_q[1].
    assign rise   = (sclk_sync_q[2:1] == 2'b01);
    assign fall   = (sclk_sync_q[2:1] == 2'b10);
    assign sdio_s = sdio_sync_q[1];

endmodule

// File: rtl/spi3w_slave_responder.sv
// Slave endpoint of the 3-wire half-duplex SPI link: decodes command frames and
// executes register writes/reads, turning SDIO around for read responses.
module spi3w_slave_responder
    import spi3w_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              spi_sclk_in,
    inout  wire               spi_sdio_pin,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] TmoMax = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TmoHit = CNT_W'(TIMEOUT_CYCLES - 1);

    logic rise;
    logic fall;
    logic sdio_s;

    spi3w_state_e         state_q,       state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic [DATA_W-1:0]    shift_q,       shift_d;
    logic [DATA_W-1:0]    tx_q,          tx_d;
    logic                 sdio_oe_q,     sdio_oe_d;
    logic                 rd_done_q,     rd_done_d;
    logic                 rd_load_q;
    logic [CNT_W-1:0]     tcnt_q,        tcnt_d;
    logic [ADDR_W-1:0]    reg_addr_q,    reg_addr_d;
    logic                 reg_wr_en_q,   reg_wr_en_d;
    logic [DATA_W-1:0]    reg_wr_data_q, reg_wr_data_d;
    logic                 reg_rd_en_q,   reg_rd_en_d;
    logic                 frame_err_q,   frame_err_d;

    logic [DATA_W-1:0] rx_byte;
    logic              last_bit;
    logic              timeout_hit;

    spi_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .clear   (!enable),
        .sclk_in (spi_sclk_in),
        .sdio_in (spi_sdio_pin),
        .rise    (rise),
        .fall    (fall),
        .sdio_s  (sdio_s)
    );

    assign rx_byte  = {shift_q[DATA_W-2:0], sdio_s};
    assign last_bit = (bit_cnt_q == 3'd7);

    // Inactivity counter; any SCLK edge restarts it, so an edge always beats a timeout.
    always_comb begin
        tcnt_d      = tcnt_q;
        timeout_hit = 1'b0;
        if (rise || fall) begin
            tcnt_d = '0;
        end else begin
            if (tcnt_q != TmoMax) begin
                tcnt_d = tcnt_q + CNT_W'(1);
            end
            timeout_hit = (tcnt_q == TmoHit);
        end
    end

    // Frame FSM next-state, shift registers and register-port strobes.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        sdio_oe_d     = sdio_oe_q;
        rd_done_d     = rd_done_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_data_d = reg_wr_data_q;
        reg_rd_en_d   = 1'b0;
        frame_err_d   = 1'b0;

        // Read data arrives one clk after the read strobe.
        if (rd_load_q) begin
            tx_d = reg_rd_data;
        end

        unique case (state_q)
            S_CMD: begin
                if (rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        reg_addr_d = rx_byte[ADDR_W-1:0];
                        if (rx_byte[CMD_RW_BIT]) begin
                            reg_rd_en_d = 1'b1;
                            state_d     = S_RTURN;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        reg_wr_en_d   = 1'b1;
                        reg_wr_data_d = rx_byte;
                        state_d       = S_CMD;
                    end
                end
            end
            S_RTURN: begin
                // Take the line on the fall after the command byte; tx_q[7] is presented.
                if (fall) begin
                    sdio_oe_d = 1'b1;
                    rd_done_d = 1'b0;
                    state_d   = S_RDRIVE;
                end
            end
            S_RDRIVE: begin
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        rd_done_d = 1'b1;
                    end
                end else if (fall) begin
                    if (rd_done_q) begin
                        sdio_oe_d = 1'b0;
                        rd_done_d = 1'b0;
                        state_d   = S_CMD;
                    end else begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase

        if (timeout_hit) begin
            state_d     = S_CMD;
            bit_cnt_d   = '0;
            sdio_oe_d   = 1'b0;
            rd_done_d   = 1'b0;
            frame_err_d = frame_active(state_q, bit_cnt_q);
        end
    end

    // State and output registers; disable behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q       <= S_CMD;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            sdio_oe_q     <= 1'b0;
            rd_done_q     <= 1'b0;
            rd_load_q     <= 1'b0;
            tcnt_q        <= '0;
            reg_addr_q    <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_data_q <= '0;
            reg_rd_en_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            sdio_oe_q     <= sdio_oe_d;
            rd_done_q     <= rd_done_d;
            rd_load_q     <= reg_rd_en_q;
            tcnt_q        <= tcnt_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_rd_en_q   <= reg_rd_en_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign spi_sdio_pin = sdio_oe_q ? tx_q[DATA_W-1] : 1'bz;

    assign reg_addr    = reg_addr_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_rd_en   = reg_rd_en_q;
    assign frame_err   = frame_err_q;
    assign busy        = frame_active(state_q, bit_cnt_q);

endmodule

// File: tb/tb_spi3w_slave_responder.sv
// Directed bench for spi3w_slave_responder: table of frames plus hand-written corner cases.
module tb_spi3w_slave_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       sclk = 1'b0;
    logic       m_oe = 1'b1;
    logic       m_out = 1'b0;
    wire        spi_sdio_pin;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'h00;
    logic       busy;
    logic       frame_err;

    int n_checks = 0;
    int n_err    = 0;

    // Monitor tallies
    int         wr_n = 0;
    int         rd_n = 0;
    int         err_n = 0;
    int         drv_n = 0;
    logic [6:0] wr_addr = '0;
    logic [6:0] rd_addr = '0;
    logic [7:0] wr_data = '0;

    assign spi_sdio_pin = m_oe ? m_out : 1'bz;

    always #5 clk = ~clk;

    spi3w_slave_responder #(
        .TIMEOUT_CYCLES (32),
        .CNT_W          (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .spi_sclk_in  (sclk),
        .spi_sdio_pin (spi_sdio_pin),
        .reg_addr     (reg_addr),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    function automatic logic [7:0] rd_model(input logic [6:0] a);
        case (a)
            7'h03:   return 8'h3C;
            7'h2A:   return 8'hC6;
            default: return 8'hFF;
        endcase
    endfunction

    // Register file read port: data valid one clk after the strobe.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= rd_model(reg_addr);
    end

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_n    <= wr_n + 1;
            wr_addr <= reg_addr;
            wr_data <= reg_wr_data;
        end
        if (reg_rd_en) begin
            rd_n    <= rd_n + 1;
            rd_addr <= reg_addr;
        end
        if (frame_err) err_n <= err_n + 1;
        if (dut.sdio_oe_q) drv_n <= drv_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        m_oe  = 1'b1;
        m_out = b;
        half_period();
        sclk = 1'b1;
        half_period();
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Master releases SDIO at the final command fall and samples on each rise.
    task automatic read_frame(input logic [7:0] cmd, output logic [7:0] rx, output int drv_ok);
        send_byte(cmd);
        m_oe   = 1'b0;
        drv_ok = 0;
        rx     = '0;
        for (int i = 7; i >= 0; i--) begin
            half_period();
            sclk  = 1'b1;
            rx[i] = spi_sdio_pin;
            if (dut.sdio_oe_q) drv_ok++;
            half_period();
            sclk = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int         wr0, rd0, e0, d0, drv_ok;
        logic [7:0] rx;

        vecs[0] = '{cmd: 8'h05, data: 8'hA5, exp: 8'hA5};
        vecs[1] = '{cmd: 8'h83, data: 8'h00, exp: 8'h3C};
        vecs[2] = '{cmd: 8'h10, data: 8'h11, exp: 8'h11};
        vecs[3] = '{cmd: 8'h12, data: 8'h22, exp: 8'h22};
        vecs[4] = '{cmd: 8'hAA, data: 8'h00, exp: 8'hC6};
        vecs[5] = '{cmd: 8'h01, data: 8'h7E, exp: 8'h7E};

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_rd_en", reg_rd_en, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_oe", dut.sdio_oe_q, 0);
        rst = 1'b0;
        // Idle timeout must not flag an error
        repeat (40) @(negedge clk);
        check("idle_timeout_no_err", err_n, 0);

        // Table of frames, written back-to-back; reads get a short turnaround gap
        foreach (vecs[k]) begin
            wr0 = wr_n; rd0 = rd_n; e0 = err_n; d0 = drv_n;
            if (vecs[k].cmd[7]) begin
                read_frame(vecs[k].cmd, rx, drv_ok);
                repeat (4) @(negedge clk);
                check($sformatf("v%0d_rd_pulses", k), rd_n - rd0, 1);
                check($sformatf("v%0d_rd_addr", k), rd_addr, {25'd0, vecs[k].cmd[6:0]});
                check($sformatf("v%0d_rx", k), rx, vecs[k].exp);
                check($sformatf("v%0d_drive_on_rises", k), drv_ok, 8);
                check($sformatf("v%0d_released", k), dut.sdio_oe_q, 0);
                check($sformatf("v%0d_no_wr", k), wr_n - wr0, 0);
            end else begin
                send_byte(vecs[k].cmd);
                send_byte(vecs[k].data);
                check($sformatf("v%0d_wr_pulses", k), wr_n - wr0, 1);
                check($sformatf("v%0d_wr_addr", k), wr_addr, {25'd0, vecs[k].cmd[6:0]});
                check($sformatf("v%0d_wr_data", k), wr_data, vecs[k].exp);
                check($sformatf("v%0d_no_drive", k), drv_n - d0, 0);
                check($sformatf("v%0d_no_rd", k), rd_n - rd0, 0);
            end
            check($sformatf("v%0d_busy_end", k), busy, 0);
            check($sformatf("v%0d_no_err", k), err_n - e0, 0);
        end

        // Partial frame abandoned by timeout
        e0 = err_n;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (2) @(negedge clk);
        check("partial_busy", busy, 1);
        repeat (40) @(negedge clk);
        check("partial_err_once", err_n - e0, 1);
        check("partial_busy_drop", busy, 0);
        wr0 = wr_n;
        send_byte(8'h01);
        send_byte(8'h7E);
        check("after_partial_wr", wr_n - wr0, 1);
        check("after_partial_addr", wr_addr, 7'h01);
        check("after_partial_data", wr_data, 8'h7E);
        check("after_partial_err", err_n - e0, 1);

        // Reset during response bit 4
        send_byte(8'h83);
        m_oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            half_period(); sclk = 1'b1; half_period(); sclk = 1'b0;
        end
        half_period();
        sclk = 1'b1;
        @(negedge clk);
        check("midrd_driving", dut.sdio_oe_q, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrd_rst_oe", dut.sdio_oe_q, 0);
        check("midrd_rst_busy", busy, 0);
        check("midrd_rst_addr", reg_addr, 0);
        check("midrd_rst_strobes", {reg_wr_en, reg_rd_en, frame_err}, 0);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd0 = rd_n;
        read_frame(8'h83, rx, drv_ok);
        repeat (4) @(negedge clk);
        check("post_rst_rd_pulses", rd_n - rd0, 1);
        check("post_rst_rx", rx, 8'h3C);
        check("post_rst_released", dut.sdio_oe_q, 0);

        // enable low in the middle of a frame
        wr0 = wr_n; rd0 = rd_n; e0 = err_n; d0 = drv_n;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        enable = 1'b0;
        @(negedge clk);
        check("dis_busy", busy, 0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_byte(8'h55);
        check("dis_no_wr", wr_n - wr0, 0);
        check("dis_no_rd", rd_n - rd0, 0);
        check("dis_no_err", err_n - e0, 0);
        check("dis_no_drive", drv_n - d0, 0);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h55);
        check("en_wr", wr_n - wr0, 1);
        check("en_addr", wr_addr, 7'h02);
        check("en_data", wr_data, 8'h55);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
